apb_cmd_master: RTL

//  APB3 requester that drives the GPIO APB slave port (PSEL/PENABLE/PWRITE/PADDR/PWDATA in; PRDATA/PREADY out).

---
 rtl/apb_cmd_master_pkg.sv | 27 ++
 rtl/apb_cmd_master_if.sv | 39 +++
 rtl/apb_cmd_master_fifo.sv | 50 +++++
 rtl/apb_cmd_master.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/apb_cmd_master_pkg.sv
// Shared types and default sizing for the APB command master slice.
// Optional feature macro: APB_MST_TIMEOUT_EN (ACCESS-phase timeout).
package apb_mst_pkg;

  localparam int unsigned APB_ADDR_W         = 32;
  localparam int unsigned APB_DATA_W         = 32;
  localparam int unsigned APB_FIFO_DEPTH     = 4;
  localparam int unsigned APB_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB3 requester bus for apb_cmd_master.
// master = the requester block, slave = its environment (command source + APB slave).
interface apb_cmd_master_if
  import apb_mst_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_cmd_master_fifo.sv
// Synchronous command FIFO (module apb_cmd_fifo); head entry is visible on pop_data.
module apb_cmd_fifo
  import apb_mst_pkg::*;
#(
  parameter int unsigned DEPTH = APB_FIFO_DEPTH,
  parameter type         T     = apb_cmd_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned        PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]     FULL_CNT = (PTR_W + 1)'(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 requester: queues read/write commands and runs each through SETUP/ACCESS.
// Define APB_MST_TIMEOUT_EN to bound the ACCESS wait to TIMEOUT_CYCLES (rsp_err=1 on expiry).
module apb_cmd_master
  import apb_mst_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned FIFO_DEPTH     = APB_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input logic                   PCLK,
  input logic                   PRESETn,
  apb_cmd_master_if.master      bus
);

  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
    $error("apb_cmd_master: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYCLES must be >= 1");
  end

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  apb_mst_state_t              state;
  cmd_t                        push_cmd;
  cmd_t                        head;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

`ifdef APB_MST_TIMEOUT_EN
  localparam int unsigned          CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]     WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]                wait_cnt;
`endif

  assign push_cmd      = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
  assign fifo_push     = bus.cmd_valid && !fifo_full;
  assign bus.cmd_ready = !fifo_full;
  // Pop exactly when the FSM moves into SETUP, from IDLE or from a consumed RESP.
  assign fifo_pop      = !fifo_empty && ((state == IDLE) || (state == RESP && bus.rsp_ready));

  apb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .push      (fifo_push),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state      <= SETUP;
            bus.PSEL   <= 1'b1;
            bus.PWRITE <= head.write;
            bus.PADDR  <= head.addr;
            bus.PWDATA <= head.wdata;
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
`ifdef APB_MST_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
        end
        ACCESS: begin
          // PREADY is checked first so a completion on the limit cycle is not an error.
          if (bus.PREADY) begin
            state         <= RESP;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
            bus.rsp_err   <= 1'b0;
          end
`ifdef APB_MST_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            state         <= RESP;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (!fifo_empty) begin
              state      <= SETUP;
              bus.PSEL   <= 1'b1;
              bus.PWRITE <= head.write;
              bus.PADDR  <= head.addr;
              bus.PWDATA <= head.wdata;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_fifo_flags: assert property (@(posedge PCLK) disable iff (!PRESETn)
    fifo_empty == (fifo_count == '0));

endmodule
